// File: rtl/my_ram_8_pkg.sv
// my_ram_8_pkg: shared sizes and FSM state type for the my_ram_8 RAM
package my_ram_8_pkg;
   localparam int DEPTH = 8;
   localparam int ADDR_W = 3;
   typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/my_ram_8_if.sv
// my_ram_8_if: data/control bundle between a host (master) and the RAM (slave)
interface my_ram_8_if import my_ram_8_pkg::*; #(parameter int WIDTH = 16);
   logic [WIDTH-1:0] in;
   logic load;
   logic [ADDR_W-1:0] address;
   logic clr;
   logic [WIDTH-1:0] out;
   logic busy;
   modport master (output in, load, address, clr, input out, busy);
   modport slave (input in, load, address, clr, output out, busy);
endinterface

// File: rtl/my_dmux_8_way.sv
// my_dmux_8_way: route a single bit to one of eight outputs by select, others 0
module my_dmux_8_way (
   input  logic       in_i,
   input  logic [2:0] sel_i,
   output logic [7:0] out_o
);
   assign out_o = in_i ? (8'd1 << sel_i) : 8'd0;
endmodule

// File: rtl/my_register.sv
// my_register: WIDTH-bit load-enabled register with synchronous active-high reset
module my_register #(parameter int WIDTH = 16) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   input  logic             load_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] q_q;
   // capture d_i when enabled, clear on reset
   always_ff @(posedge clk) begin
      if (reset) q_q <= '0;
      else if (load_i) q_q <= d_i;
   end
   assign q_o = q_q;
endmodule

// File: rtl/my_ram_8.sv
// my_ram_8: 8-word RAM with an 8-cycle clear sweep; MY_RAM_8_WRITE_THROUGH_EN enables read-during-write bypass
module my_ram_8 import my_ram_8_pkg::*; #(parameter int WIDTH = 16) (
   input logic      clk,
   input logic      reset,
   my_ram_8_if.slave bus
);
   logic [DEPTH-1:0] sel;
   logic [WIDTH-1:0] word [DEPTH];
   state_t state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic busy;
   assign busy = state_q == CLEAR;
   assign bus.busy = busy;
   my_dmux_8_way u_dmux (.in_i(bus.load), .sel_i(bus.address), .out_o(sel));
   // during a sweep the counter owns the write port and forces zeros; host writes are dropped
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      my_register #(.WIDTH(WIDTH)) u_reg (
         .clk(clk),
         .reset(reset),
         .d_i(busy ? '0 : bus.in),
         .load_i(busy ? cnt_q == ADDR_W'(i) : sel[i]),
         .q_o(word[i])
      );
   end
   // state and sweep counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
      end
   end
   // start a sweep on clr from IDLE; finish after the word-7 clear so the wrap never restarts it
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         if (bus.clr) begin
            state_d = CLEAR;
            cnt_d = '0;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
   end
`ifdef MY_RAM_8_WRITE_THROUGH_EN
   assign bus.out = (bus.load && !busy && !reset) ? bus.in : word[bus.address];
`else
   assign bus.out = word[bus.address];
`endif
endmodule

// File: tb/tb_my_ram_8.sv
// tb_my_ram_8: table vectors, directed sweep corners and random traffic against a reference model
module tb_my_ram_8;
   localparam int W = 16;
`ifdef MY_RAM_8_WRITE_THROUGH_EN
   localparam bit WT = 1'b1;
`else
   localparam bit WT = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b0;
   my_ram_8_if #(.WIDTH(W)) bus ();
   my_ram_8 #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int total = 0;
   int bad = 0;
   logic [W-1:0] mem [8];
   int left = 0;
   typedef struct {
      string n;
      bit r, ld, c;
      logic [2:0] a;
      logic [W-1:0] d;
      logic [W-1:0] eo;
      bit eb;
   } vec_t;
   vec_t tv [$];

   function automatic logic [W-1:0] exp_out();
      return (WT && bus.load && left == 0 && !reset) ? bus.in : mem[bus.address];
   endfunction

   task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, got, exp);
      end
   endtask

   task automatic set(input bit r, input bit ld, input bit c, input logic [2:0] a, input logic [W-1:0] d);
      reset = r;
      bus.load = ld;
      bus.clr = c;
      bus.address = a;
      bus.in = d;
   endtask

   // reference: a sweep is just "clear the next of 8 words each cycle"; otherwise plain RAM semantics
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         foreach (mem[i]) mem[i] = '0;
         left = 0;
      end else if (left > 0) begin
         mem[8 - left] = '0;
         left--;
      end else begin
         if (bus.load) mem[bus.address] = bus.in;
         if (bus.clr) left = 8;
      end
      #1;
   endtask

   task automatic idle_in();
      reset = 1'b0;
      bus.load = 1'b0;
      bus.clr = 1'b0;
   endtask

   task automatic add(input string n, input bit r, input bit ld, input bit c, input logic [2:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] eo, input bit eb);
      vec_t v;
      v.n = n; v.r = r; v.ld = ld; v.c = c; v.a = a; v.d = d; v.eo = eo; v.eb = eb;
      tv.push_back(v);
   endtask

   initial begin
      int n;
      foreach (mem[i]) mem[i] = '0;
      set(1, 0, 0, 0, 0);
      add("reset", 1, 0, 0, 0, 16'h0, 16'h0, 0);
      for (int i = 0; i < 8; i++) add($sformatf("rst_rd%0d", i), 0, 0, 0, 3'(i), 16'h0, 16'h0, 0);
      add("wr3", 0, 1, 0, 3, 16'hBEEF, 16'hBEEF, 0);
      add("wr5", 0, 1, 0, 5, 16'h1234, 16'h1234, 0);
      add("rd3", 0, 0, 0, 3, 16'h0, 16'hBEEF, 0);
      add("rd5", 0, 0, 0, 5, 16'h0, 16'h1234, 0);
      add("rd0", 0, 0, 0, 0, 16'h0, 16'h0, 0);
      add("rst_prio", 1, 1, 1, 5, 16'hFFFF, 16'h0, 0);
      add("rd3_after_rst", 0, 0, 0, 3, 16'h0, 16'h0, 0);
      foreach (tv[k]) begin
         set(tv[k].r, tv[k].ld, tv[k].c, tv[k].a, tv[k].d);
         tick();
         idle_in();
         #1;
         chk({tv[k].n, "_out"}, bus.out, tv[k].eo);
         chk({tv[k].n, "_busy"}, W'(bus.busy), W'(tv[k].eb));
      end

      // fill 1..8, sweep, drop a write mid-sweep
      for (int i = 0; i < 8; i++) begin
         set(0, 1, 0, 3'(i), W'(i + 1));
         tick();
      end
      set(0, 0, 1, 0, 0);
      tick();
      idle_in();
      for (int k = 0; k < 8; k++) begin
         bus.address = 3'(k);
         #1;
         chk($sformatf("sweep_busy%0d", k), W'(bus.busy), W'(1));
         chk($sformatf("sweep_unswept%0d", k), bus.out, W'(k + 1));
         if (k == 3) begin
            bus.address = 3'd0;
            bus.in = 16'hAAAA;
            bus.load = 1'b1;
         end
         tick();
         bus.load = 1'b0;
      end
      chk("sweep_done_busy", W'(bus.busy), W'(0));
      for (int j = 0; j < 8; j++) begin
         bus.address = 3'(j);
         #1;
         chk($sformatf("swept_rd%0d", j), bus.out, 16'h0);
      end

      // same-edge clr and load to word 7
      set(0, 1, 1, 7, 16'h00FF);
      tick();
      idle_in();
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("same_edge_w7_c%0d", k), bus.out, k < 8 ? 16'h00FF : 16'h0);
      end
      chk("same_edge_busy_end", W'(bus.busy), W'(0));

      // reset on the 4th sweep cycle
      set(0, 1, 0, 4, 16'h4444);
      tick();
      set(0, 0, 1, 4, 0);
      tick();
      idle_in();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", W'(bus.busy), W'(0));
      for (int j = 0; j < 8; j++) begin
         bus.address = 3'(j);
         #1;
         chk($sformatf("abort_rd%0d", j), bus.out, 16'h0);
      end
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      n = 0;
      while (bus.busy && n < 20) begin
         n++;
         tick();
      end
      chk("resweep_len", W'(n), W'(8));

      // read during write
      set(0, 1, 0, 2, 16'h1111);
      tick();
      bus.in = 16'h5A5A;
      #1;
      chk("rdw_before", bus.out, WT ? 16'h5A5A : 16'h1111);
      tick();
      idle_in();
      #1;
      chk("rdw_after", bus.out, 16'h5A5A);

      // random traffic vs model
      for (int t = 0; t < 400; t++) begin
         set($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
             3'($urandom_range(0, 7)), W'($urandom));
         #1;
         chk("rnd_comb", bus.out, exp_out());
         tick();
         chk("rnd_busy", W'(bus.busy), W'(left > 0));
         chk("rnd_out", bus.out, exp_out());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
